cu_ram_arbiter: RTL

Two-port arbiter and sequencer for the control-unit scratch RAM. Port 0 (control unit) and port 1 (I/O / debug loader) issue single read or write requests over a valid/ready handshake. The block grants one request at a time with round-robin fairness and drives the RAM command lines for exactly one cycle. The RAM acts on the falling edge of that cycle, and the block returns the read data or write acknowledge to the granted port.

---
 rtl/cu_ram_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cu_ram_arbiter.sv
// Two-port round-robin arbiter for the control-unit scratch RAM: grants one
// single-beat request at a time, drives the RAM strobes for one cycle, and returns the response.
`timescale 1ns/1ps
module cu_ram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp0_valid,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state_r, state_s;
  logic                last_grant_r, last_grant_s;
  logic                owner_r, owner_s;
  logic                grant0_s, grant1_s;
  logic [ADDR_W-1:0]   ram_addr_r, ram_addr_s;
  logic [DATA_W-1:0]   ram_wdata_r, ram_wdata_s;
  logic                ram_en_r, ram_en_s;
  logic                ram_read_r, ram_read_s;
  logic                ram_write_r, ram_write_s;
  logic                rsp0_valid_r, rsp0_valid_s;
  logic                rsp1_valid_r, rsp1_valid_s;
  logic [DATA_W-1:0]   rsp_data_r, rsp_data_s;

  // Next-state, grant and next-output logic; the synchronous reset is folded in here.
  always_comb begin
    state_s      = state_r;
    last_grant_s = last_grant_r;
    owner_s      = owner_r;
    grant0_s     = 1'b0;
    grant1_s     = 1'b0;
    ram_addr_s   = ram_addr_r;
    ram_wdata_s  = ram_wdata_r;
    ram_en_s     = 1'b0;
    ram_read_s   = 1'b0;
    ram_write_s  = 1'b0;
    rsp0_valid_s = 1'b0;
    rsp1_valid_s = 1'b0;
    rsp_data_s   = rsp_data_r;
    if (!reset) begin
      // last_grant of 1 lets port 0 win the first tie
      state_s      = IDLE;
      last_grant_s = 1'b1;
      owner_s      = 1'b0;
      ram_addr_s   = {ADDR_W{1'b0}};
      ram_wdata_s  = {DATA_W{1'b0}};
      rsp_data_s   = {DATA_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          grant0_s = req0_valid && (!req1_valid || last_grant_r);
          grant1_s = req1_valid && (!req0_valid || !last_grant_r);
          if (grant0_s) begin
            state_s      = ACCESS;
            owner_s      = 1'b0;
            last_grant_s = 1'b0;
            ram_addr_s   = req0_addr;
            ram_wdata_s  = req0_wdata;
            ram_en_s     = 1'b1;
            ram_write_s  = req0_we;
            ram_read_s   = !req0_we;
          end else if (grant1_s) begin
            state_s      = ACCESS;
            owner_s      = 1'b1;
            last_grant_s = 1'b1;
            ram_addr_s   = req1_addr;
            ram_wdata_s  = req1_wdata;
            ram_en_s     = 1'b1;
            ram_write_s  = req1_we;
            ram_read_s   = !req1_we;
          end else begin
            state_s = IDLE;
          end
        end
        ACCESS: begin
          // RAM completed on the falling edge; ram_rdata is only trusted here
          state_s = IDLE;
          if (owner_r) begin
            rsp1_valid_s = 1'b1;
          end else begin
            rsp0_valid_s = 1'b1;
          end
          if (ram_read_r) begin
            rsp_data_s = ram_rdata;
          end else begin
            rsp_data_s = {DATA_W{1'b0}};
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and registered-output update.
  always_ff @(posedge clk) begin
    state_r      <= state_s;
    last_grant_r <= last_grant_s;
    owner_r      <= owner_s;
    ram_addr_r   <= ram_addr_s;
    ram_wdata_r  <= ram_wdata_s;
    ram_en_r     <= ram_en_s;
    ram_read_r   <= ram_read_s;
    ram_write_r  <= ram_write_s;
    rsp0_valid_r <= rsp0_valid_s;
    rsp1_valid_r <= rsp1_valid_s;
    rsp_data_r   <= rsp_data_s;
  end

  assign req0_ready = grant0_s;
  assign req1_ready = grant1_s;
  assign ram_addr   = ram_addr_r;
  assign ram_wdata  = ram_wdata_r;
  assign ram_en     = ram_en_r;
  assign ram_read   = ram_read_r;
  assign ram_write  = ram_write_r;
  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign rsp_data   = rsp_data_r;

endmodule
